// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_rx
// Brief    : SPI mode-0 slave receiver with input synchronizers, valid/ack word
//            handshake, overrun/frame errors; optional MISO via SPI_SLAVE_MISO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_cs,
  input  logic                     s_sclk,
  input  logic                     s_mosi,
  input  logic                     rx_ack,
`ifdef SPI_SLAVE_MISO_EN
  input  logic [WIDTH-1:0]         tx_data,
  output logic                     s_miso,
`endif
  output logic [WIDTH-1:0]         rx_data,
  output logic                     rx_valid,
  output logic                     rx_overrun,
  output logic                     frame_err,
  output logic [$clog2(WIDTH):0]   bit_count
);

  localparam int                 c_CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_WORD_END = c_CNT_W'(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_q;
  logic [WIDTH-1:0]       r_shreg;

  logic                   w_cs_n_s;
  logic                   w_sclk_s;
  logic                   w_mosi_s;
  logic                   w_rise;
  logic                   w_word_done;
  logic [c_CNT_W-1:0]     w_cnt_next;
  logic [WIDTH-1:0]       w_shift_next;

  // All SPI pins are asynchronous to clk; every use goes through the final stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs_sync   <= '0;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_sclk_q    <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], s_cs};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], s_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], s_mosi};
      r_sclk_q    <= w_sclk_s;
    end
  end

  assign w_cs_n_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_s     = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s     = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise       = w_sclk_s & ~r_sclk_q;
  assign w_cnt_next   = bit_count + c_CNT_ONE;
  assign w_shift_next = {r_shreg[WIDTH-2:0], w_mosi_s};
  assign w_word_done  = (r_state == ST_SHIFT) && !w_cs_n_s && w_rise &&
                        (w_cnt_next == c_WORD_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      bit_count  <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (!w_cs_n_s) begin
            r_state   <= ST_SHIFT;
            bit_count <= '0;
            r_shreg   <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_cs_n_s) begin
            // A partial word is simply dropped; only the error pulse survives.
            r_state   <= ST_IDLE;
            bit_count <= '0;
            if (bit_count != '0) begin
              frame_err <= 1'b1;
            end
          end else if (w_rise) begin
            r_shreg <= w_shift_next;
            if (w_word_done) begin
              bit_count <= '0;
              if (!rx_valid || rx_ack) begin
                rx_data  <= w_shift_next;
                rx_valid <= 1'b1;
              end else begin
                rx_overrun <= 1'b1;
              end
            end else begin
              bit_count <= w_cnt_next;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_MISO_EN
  logic [WIDTH-1:0] r_tx_shreg;
  logic             r_tx_hold;
  logic             w_fall;

  assign w_fall = ~w_sclk_s & r_sclk_q;

  // After a word wrap the freshly loaded MSB must survive the falling edge
  // that closes the previous word, so that one fall is absorbed by r_tx_hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_shreg <= '0;
      r_tx_hold  <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (!w_cs_n_s) begin
        r_tx_shreg <= tx_data;
        r_tx_hold  <= 1'b0;
      end
    end else if (!w_cs_n_s) begin
      if (w_word_done) begin
        r_tx_shreg <= tx_data;
        r_tx_hold  <= 1'b1;
      end else if (w_fall) begin
        if (r_tx_hold) begin
          r_tx_hold <= 1'b0;
        end else begin
          r_tx_shreg <= {r_tx_shreg[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  assign s_miso = (r_state == ST_SHIFT) ? r_tx_shreg[WIDTH-1] : 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_rx
// Brief    : Directed self-checking bench for spi_slave_rx (MISO part only
//            when SPI_SLAVE_MISO_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_cs;
  logic       s_sclk;
  logic       s_mosi;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       frame_err;
  logic [3:0] bit_count;
`ifdef SPI_SLAVE_MISO_EN
  logic [7:0] tx_data;
  logic       s_miso;
  logic [7:0] miso_cap;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int fe_count = 0;
  int fe_base;

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) fe_count++;

  spi_slave_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_cs       (s_cs),
    .s_sclk     (s_sclk),
    .s_mosi     (s_mosi),
    .rx_ack     (rx_ack),
`ifdef SPI_SLAVE_MISO_EN
    .tx_data    (tx_data),
    .s_miso     (s_miso),
`endif
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err),
    .bit_count  (bit_count)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b);
    s_mosi = b;
    tick(6);
    s_sclk = 1'b1;
`ifdef SPI_SLAVE_MISO_EN
    miso_cap = {miso_cap[6:0], s_miso};
`endif
    tick(6);
    s_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) spi_bit(v[i]);
  endtask

  task automatic cs_low();
    s_cs = 1'b0;
    tick(6);
  endtask

  task automatic cs_high();
    tick(6);
    s_cs = 1'b1;
    tick(6);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    tick(1);
  endtask

  initial begin
    reset  = 1'b1;
    s_cs   = 1'b1;
    s_sclk = 1'b0;
    s_mosi = 1'b0;
    rx_ack = 1'b0;
`ifdef SPI_SLAVE_MISO_EN
    tx_data  = 8'h00;
    miso_cap = 8'h00;
`endif
    tick(3);
    check("reset rx_data",    32'(rx_data),    32'h0);
    check("reset rx_valid",   32'(rx_valid),   32'h0);
    check("reset rx_overrun", 32'(rx_overrun), 32'h0);
    check("reset frame_err",  32'(frame_err),  32'h0);
    check("reset bit_count",  32'(bit_count),  32'h0);
    reset = 1'b0;
    tick(6);

    // Single word, no ack
    fe_base = fe_count;
    cs_low();
    spi_byte(8'hA5);
    cs_high();
    check("single rx_data",   32'(rx_data),            32'hA5);
    check("single rx_valid",  32'(rx_valid),           32'h1);
    check("single frame_err", 32'(fe_count - fe_base), 32'h0);
    check("single bit_count", 32'(bit_count),          32'h0);
    check("single overrun",   32'(rx_overrun),         32'h0);
    ack_pulse();
    check("ack clears valid", 32'(rx_valid), 32'h0);

    // Back-to-back words with an ack between them
    cs_low();
    spi_byte(8'h10);
    tick(3);
    check("b2b first data",  32'(rx_data),  32'h10);
    check("b2b first valid", 32'(rx_valid), 32'h1);
    ack_pulse();
    check("b2b ack valid",   32'(rx_valid), 32'h0);
    spi_byte(8'h21);
    cs_high();
    check("b2b second data",  32'(rx_data),    32'h21);
    check("b2b second valid", 32'(rx_valid),   32'h1);
    check("b2b overrun",      32'(rx_overrun), 32'h0);
    ack_pulse();

    // Overrun: second word dropped, flag sticky
    cs_low();
    spi_byte(8'h3C);
    spi_byte(8'hC3);
    cs_high();
    check("ovr rx_data",  32'(rx_data),    32'h3C);
    check("ovr rx_valid", 32'(rx_valid),   32'h1);
    check("ovr flag",     32'(rx_overrun), 32'h1);
    ack_pulse();
    check("ovr sticky",   32'(rx_overrun), 32'h1);
    check("ovr ack valid", 32'(rx_valid),  32'h0);

    // Truncated frame: 3 bits then chip select released
    fe_base = fe_count;
    cs_low();
    spi_bit(1'b1);
    spi_bit(1'b0);
    spi_bit(1'b1);
    tick(2);
    check("trunc partial count", 32'(bit_count), 32'h3);
    cs_high();
    check("trunc frame_err pulses", 32'(fe_count - fe_base), 32'h1);
    check("trunc rx_valid",         32'(rx_valid),            32'h0);
    check("trunc bit_count",        32'(bit_count),           32'h0);

    // Reset mid-frame after 5 bits
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(i[0]);
    tick(2);
    check("midrst partial count", 32'(bit_count), 32'h5);
    reset = 1'b1;
    #1;
    check("midrst rx_data",   32'(rx_data),    32'h0);
    check("midrst rx_valid",  32'(rx_valid),   32'h0);
    check("midrst overrun",   32'(rx_overrun), 32'h0);
    check("midrst frame_err", 32'(frame_err),  32'h0);
    check("midrst bit_count", 32'(bit_count),  32'h0);
    tick(2);
    reset = 1'b0;
    fe_base = fe_count;
    cs_high();
    cs_low();
    spi_byte(8'h5A);
    cs_high();
    check("post-rst rx_data",   32'(rx_data),            32'h5A);
    check("post-rst rx_valid",  32'(rx_valid),           32'h1);
    check("post-rst overrun",   32'(rx_overrun),         32'h0);
    check("post-rst frame_err", 32'(fe_count - fe_base), 32'h0);
    ack_pulse();

`ifdef SPI_SLAVE_MISO_EN
    // MISO echo of a loaded response word
    tx_data = 8'h3C;
    check("miso idle before", 32'(s_miso), 32'h0);
    cs_low();
    spi_byte(8'hFF);
    cs_high();
    check("miso captured", 32'(miso_cap), 32'h3C);
    check("miso rx_data",  32'(rx_data),  32'hFF);
    check("miso idle after", 32'(s_miso), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI mode-0 slave that receives serial frames driven by the team's `spi_master` (chip select, serial clock, data line) and reassembles them into parallel words for the BIST comparator and LFSR check path. It oversamples all SPI inputs in the system clock domain through synchronizers and detects serial-clock edges. Completed words are presented on a valid/ack handshake. Error flags report overrun and truncated frames, and an optional MISO return path shifts out a loaded response word.

## Interface
- `WIDTH`, 8: bits per word, MSB first; must be ≥2.
- `SYNC_STAGES`, 2: synchronizer flops on `s_cs`, `s_sclk`, `s_mosi`; must be ≥2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset; clears every register.
- `s_cs`  in  1  chip select, active low, async to `clk`.
- `s_sclk`  in  1  SPI clock, async to `clk`; idles low.
- `s_mosi`  in  1  serial data from master.
- `rx_ack`  in  1  consumer accepts `rx_data`; ignored unless `rx_valid`=1.
- `rx_data`  out  WIDTH  last accepted word; reset 0.
- `rx_valid`  out  1  word available; reset 0.
- `rx_overrun`  out  1  sticky: word completed while `rx_valid`=1; reset 0.
- `frame_err`  out  1  one-cycle pulse: `s_cs` deasserted mid-word; reset 0.
- `bit_count`  out  log2(WIDTH)+1  bits received in current word; reset 0.
- `tx_data`  in  WIDTH  response word (only with `SPI_SLAVE_MISO_EN`).
- `s_miso`  out  1  serial response (only with `SPI_SLAVE_MISO_EN`); reset 0.

## Operation
- Synchronizers: each SPI input passes through SYNC_STAGES flops. `cs_n_s`, `sclk_s`, `mosi_s` are the final stage outputs. `sclk_q` holds `sclk_s` delayed one cycle.
- Edges: `rise = sclk_s & ~sclk_q`; `fall = ~sclk_s & sclk_q`.
- FSM states: IDLE, SHIFT.
  - IDLE → SHIFT when `cs_n_s`=0. Entering SHIFT clears `bit_count` and the shift register.
  - SHIFT → IDLE when `cs_n_s`=1.
  - If `bit_count`≠0 when leaving SHIFT, `frame_err` pulses for 1 cycle and the partial word is discarded.
- In SHIFT, each `rise` does `shreg <= {shreg[WIDTH-2:0], mosi_s}` and increments `bit_count`.
- When the increment reaches WIDTH:
  - `bit_count` wraps to 0.
  - If `rx_valid`=0: `rx_data` <= completed word and `rx_valid` <= 1.
  - If `rx_valid`=1: the word is dropped, `rx_data` is unchanged, and `rx_overrun` <= 1.
  - Back-to-back words continue within one chip-select assertion.
- Handshake: `rx_ack`=1 while `rx_valid`=1 clears `rx_valid` on the next edge.
  - If a word completes in the same cycle as `rx_ack`, the new word is loaded and `rx_valid` stays 1.
  - No overrun is flagged in that case.
- Edges seen while in IDLE are ignored.
- `rx_overrun` clears only on `reset`.
- `reset` mid-frame:
  - All outputs return to reset values and the FSM goes to IDLE.
  - If `s_cs` is still low after `reset` releases, the FSM re-enters SHIFT and counts from the next `rise`. The master is responsible for resynchronizing.

## Timing
- Input constraint: `s_sclk` high and low phases each ≥ SYNC_STAGES+1 `clk` periods. `s_mosi` is stable over the same window around the `s_sclk` rising edge.
- Rising edge detection: `rise` is asserted SYNC_STAGES cycles after the first `clk` edge that samples `s_sclk`=1.
- Receive latency: `rx_valid` rises on the `clk` edge after the `rise` cycle of bit WIDTH-1. That is SYNC_STAGES+1 `clk` edges after the raw `s_sclk` rise is first sampled.
- `frame_err` is asserted SYNC_STAGES+1 edges after raw `s_cs` rising is first sampled.
- `rx_valid` clears one edge after `rx_ack` is sampled.

## Configuration
- `SPI_SLAVE_MISO_EN` defined: the MISO response path is compiled in.
  - `tx_data` is captured into a transmit shift register on SHIFT entry and on each word wrap.
  - `s_miso` is driven with the MSB immediately.
  - Each `fall` shifts the register left, so `s_miso` presents the next bit.
  - `s_miso` is 0 in IDLE.
- `SPI_SLAVE_MISO_EN` undefined: the `tx_data` and `s_miso` ports and all MISO logic are absent. Receive behaviour is identical.

## Test plan
- Receive single word: `s_cs` low, shift 0xA5 MSB first, `s_cs` high, no ack → `rx_data`=0xA5, `rx_valid`=1, `frame_err` never pulses, `bit_count`=0.
- Back-to-back words: 0x10 then 0x21 in one `s_cs` window, `rx_ack` pulsed after the first word → `rx_data` reads 0x10, then 0x21, and `rx_overrun`=0.
- Overrun: 0x3C then 0xC3 with no ack → `rx_data`=0x3C, `rx_valid`=1, `rx_overrun`=1.
- Truncated frame: `s_cs` low, 3 rising edges, `s_cs` high → `frame_err` is a single 1-cycle pulse, `rx_valid`=0, `bit_count`=0.
- Reset mid-frame: assert `reset` after 5 bits → all outputs are 0 immediately. Then a new full frame of 0x5A → `rx_data`=0x5A.
- MISO echo (`SPI_SLAVE_MISO_EN` defined): `tx_data`=0x3C while receiving 0xFF → the master samples 0x3C on `s_miso`, and `rx_data`=0xFF.
